// File: rtl/thermo_sel_pkg.sv
// rtl/thermo_sel_pkg.sv - shared states, thermometer constants and decode for thermo_sel_decoder
package thermo_sel_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      ERR  = 2'd2
   } state_e;

   localparam logic [2:0] T0 = 3'b000;
   localparam logic [2:0] T1 = 3'b001;
   localparam logic [2:0] T2 = 3'b011;
   localparam logic [2:0] T3 = 3'b111;

   // Returns {legal, level}; illegal codes report level 0.
   function automatic logic [2:0] thermo_decode(input logic [2:0] code);
      logic [2:0] r;
      case (code)
         T0:      r = 3'b100;
         T1:      r = 3'b101;
         T2:      r = 3'b110;
         T3:      r = 3'b111;
         default: r = 3'b000;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/thermo2bin.sv
// rtl/thermo2bin.sv - combinational thermometer legality check and binary decode
module thermo2bin
   import thermo_sel_pkg::*;
(
   input  logic [2:0] code,
   output logic       legal,
   output logic [1:0] lvl
);

   logic [2:0] dec;

   // Single decode shared by the FSM and the live level register.
   always_comb begin
      dec   = thermo_decode(code);
      legal = dec[2];
      lvl   = dec[1:0];
   end

endmodule

// File: rtl/thermo_sel_decoder.sv
// rtl/thermo_sel_decoder.sv - peak-tracking thermometer press decoder; THERMO_SEL_ERRCNT_EN enables err_cnt
module thermo_sel_decoder
   import thermo_sel_pkg::*;
#(
   parameter int unsigned MAX_HOLD = 1
)(
   input  logic       clk,
   input  logic       reset,
   input  logic [2:0] S,
   output logic [1:0] level,
   output logic [1:0] sel,
   output logic       sel_valid,
   output logic       err,
   output logic [7:0] err_cnt
);

   localparam logic [3:0] MAX_HOLD_C = 4'(MAX_HOLD);

   logic       s_legal;
   logic [1:0] s_lvl;

   state_e     state_q, state_d;
   logic [1:0] peak_q, peak_d;
   logic [3:0] hold_q, hold_d;
   logic [1:0] level_q, level_d;
   logic [1:0] sel_q, sel_d;
   logic       sel_valid_q, sel_valid_d;
   logic       err_q, err_d;

   thermo2bin u_thermo2bin (
      .code  (S),
      .legal (s_legal),
      .lvl   (s_lvl)
   );

   // Next-state logic: track the peak level of a press sequence and commit it on return to 000.
   always_comb begin
      state_d     = state_q;
      peak_d      = peak_q;
      hold_d      = hold_q;
      sel_d       = sel_q;
      sel_valid_d = 1'b0;
      level_d     = s_lvl;
      case (state_q)
         IDLE: begin
            if (S == T1) begin
               state_d = RUN;
               peak_d  = 2'd1;
               hold_d  = 4'd1;
            end else if (S != T0) begin
               state_d = ERR;
            end
         end
         RUN: begin
            if (S == T0) begin
               sel_d       = peak_q;
               sel_valid_d = 1'b1;
               state_d     = IDLE;
            end else if (s_legal && ({1'b0, s_lvl} == ({1'b0, peak_q} + 3'd1))) begin
               peak_d = peak_q + 2'd1;
               hold_d = 4'd1;
            end else if (s_legal && (s_lvl == peak_q) && (hold_q < MAX_HOLD_C)) begin
               hold_d = hold_q + 4'd1;
            end else begin
               // hold exhausted, illegal code, level skip or drop to a nonzero level
               state_d = ERR;
            end
         end
         ERR: begin
            if (S == T0) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      err_d = (state_d == ERR);
   end

   // State and registered outputs; reset discards any partial sequence.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         peak_q      <= 2'd0;
         hold_q      <= 4'd0;
         level_q     <= 2'd0;
         sel_q       <= 2'd0;
         sel_valid_q <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         peak_q      <= peak_d;
         hold_q      <= hold_d;
         level_q     <= level_d;
         sel_q       <= sel_d;
         sel_valid_q <= sel_valid_d;
         err_q       <= err_d;
      end
   end

`ifdef THERMO_SEL_ERRCNT_EN
   logic [7:0] err_cnt_q, err_cnt_d;

   // Count entries into ERR only, saturating at 255.
   always_comb begin
      err_cnt_d = err_cnt_q;
      if ((state_d == ERR) && (state_q != ERR) && (err_cnt_q != 8'hFF))
         err_cnt_d = err_cnt_q + 8'd1;
   end

   // Error entry counter register.
   always_ff @(posedge clk) begin
      if (reset) err_cnt_q <= 8'd0;
      else       err_cnt_q <= err_cnt_d;
   end

   assign err_cnt = err_cnt_q;
`else
   assign err_cnt = 8'd0;
`endif

   assign level     = level_q;
   assign sel       = sel_q;
   assign sel_valid = sel_valid_q;
   assign err       = err_q;

endmodule

// File: tb/tb_thermo_sel_decoder.sv
// tb/tb_thermo_sel_decoder.sv - self-checking bench for thermo_sel_decoder
module tb_thermo_sel_decoder;

`ifdef THERMO_SEL_ERRCNT_EN
   localparam bit CNT_ON = 1'b1;
`else
   localparam bit CNT_ON = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset;
   logic [2:0] S;
   logic [1:0] level, sel, level2, sel2;
   logic       sel_valid, err, sel_valid2, err2;
   logic [7:0] err_cnt, err_cnt2;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   thermo_sel_decoder #(.MAX_HOLD(1)) dut (
      .clk(clk), .reset(reset), .S(S),
      .level(level), .sel(sel), .sel_valid(sel_valid), .err(err), .err_cnt(err_cnt)
   );

   thermo_sel_decoder #(.MAX_HOLD(2)) dut2 (
      .clk(clk), .reset(reset), .S(S),
      .level(level2), .sel(sel2), .sel_valid(sel_valid2), .err(err2), .err_cnt(err_cnt2)
   );

   typedef struct {
      logic [2:0] s;
      logic [1:0] lvl;
      logic [1:0] sel;
      logic       vld;
      logic       err;
      logic [7:0] cnt;
   } vec_t;

   vec_t vt [34];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic logic [7:0] ecnt(input int n);
      return CNT_ON ? 8'(n) : 8'd0;
   endfunction

   task automatic step(input logic [2:0] s);
      @(negedge clk);
      S = s;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      S     = 3'b000;
      @(posedge clk);
      @(posedge clk);
      #1;
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      S     = 3'b000;

      vt[0]  = '{3'b000, 2'd0, 2'd0, 1'b0, 1'b0, 8'd0};
      vt[1]  = '{3'b001, 2'd1, 2'd0, 1'b0, 1'b0, 8'd0};
      vt[2]  = '{3'b011, 2'd2, 2'd0, 1'b0, 1'b0, 8'd0};
      vt[3]  = '{3'b111, 2'd3, 2'd0, 1'b0, 1'b0, 8'd0};
      vt[4]  = '{3'b000, 2'd0, 2'd3, 1'b1, 1'b0, 8'd0};
      vt[5]  = '{3'b000, 2'd0, 2'd3, 1'b0, 1'b0, 8'd0};
      vt[6]  = '{3'b001, 2'd1, 2'd3, 1'b0, 1'b0, 8'd0};
      vt[7]  = '{3'b000, 2'd0, 2'd1, 1'b1, 1'b0, 8'd0};
      vt[8]  = '{3'b001, 2'd1, 2'd1, 1'b0, 1'b0, 8'd0};
      vt[9]  = '{3'b011, 2'd2, 2'd1, 1'b0, 1'b0, 8'd0};
      vt[10] = '{3'b000, 2'd0, 2'd2, 1'b1, 1'b0, 8'd0};
      vt[11] = '{3'b001, 2'd1, 2'd2, 1'b0, 1'b0, 8'd0};
      vt[12] = '{3'b001, 2'd1, 2'd2, 1'b0, 1'b1, 8'd1};
      vt[13] = '{3'b001, 2'd1, 2'd2, 1'b0, 1'b1, 8'd1};
      vt[14] = '{3'b000, 2'd0, 2'd2, 1'b0, 1'b0, 8'd1};
      vt[15] = '{3'b001, 2'd1, 2'd2, 1'b0, 1'b0, 8'd1};
      vt[16] = '{3'b111, 2'd3, 2'd2, 1'b0, 1'b1, 8'd2};
      vt[17] = '{3'b000, 2'd0, 2'd2, 1'b0, 1'b0, 8'd2};
      vt[18] = '{3'b101, 2'd0, 2'd2, 1'b0, 1'b1, 8'd3};
      vt[19] = '{3'b000, 2'd0, 2'd2, 1'b0, 1'b0, 8'd3};
      vt[20] = '{3'b001, 2'd1, 2'd2, 1'b0, 1'b0, 8'd3};
      vt[21] = '{3'b011, 2'd2, 2'd2, 1'b0, 1'b0, 8'd3};
      vt[22] = '{3'b001, 2'd1, 2'd2, 1'b0, 1'b1, 8'd4};
      vt[23] = '{3'b000, 2'd0, 2'd2, 1'b0, 1'b0, 8'd4};
      vt[24] = '{3'b001, 2'd1, 2'd2, 1'b0, 1'b0, 8'd4};
      vt[25] = '{3'b110, 2'd0, 2'd2, 1'b0, 1'b1, 8'd5};
      vt[26] = '{3'b000, 2'd0, 2'd2, 1'b0, 1'b0, 8'd5};
      vt[27] = '{3'b111, 2'd3, 2'd2, 1'b0, 1'b1, 8'd6};
      vt[28] = '{3'b000, 2'd0, 2'd2, 1'b0, 1'b0, 8'd6};
      vt[29] = '{3'b001, 2'd1, 2'd2, 1'b0, 1'b0, 8'd6};
      vt[30] = '{3'b011, 2'd2, 2'd2, 1'b0, 1'b0, 8'd6};
      vt[31] = '{3'b111, 2'd3, 2'd2, 1'b0, 1'b0, 8'd6};
      vt[32] = '{3'b111, 2'd3, 2'd2, 1'b0, 1'b1, 8'd7};
      vt[33] = '{3'b000, 2'd0, 2'd2, 1'b0, 1'b0, 8'd7};

      // reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_level", level, 0);
      chk("rst_sel", sel, 0);
      chk("rst_sel_valid", sel_valid, 0);
      chk("rst_err", err, 0);
      chk("rst_err_cnt", err_cnt, 0);
      @(negedge clk);
      reset = 1'b0;

      // table vectors, MAX_HOLD=1 instance
      for (int i = 0; i < 34; i++) begin
         step(vt[i].s);
         chk($sformatf("v%0d_level", i), level, vt[i].lvl);
         chk($sformatf("v%0d_sel", i), sel, vt[i].sel);
         chk($sformatf("v%0d_sel_valid", i), sel_valid, vt[i].vld);
         chk($sformatf("v%0d_err", i), err, vt[i].err);
         chk($sformatf("v%0d_err_cnt", i), err_cnt, ecnt(int'(vt[i].cnt)));
      end

      // reset in mid-sequence: no commit, sel cleared
      step(3'b001);
      step(3'b011);
      @(negedge clk);
      reset = 1'b1;
      S     = 3'b011;
      @(posedge clk);
      #1;
      chk("midrst_sel", sel, 0);
      chk("midrst_level", level, 0);
      chk("midrst_err_cnt", err_cnt, 0);
      @(negedge clk);
      reset = 1'b0;
      step(3'b000);
      chk("midrst_sel_valid", sel_valid, 0);
      chk("midrst_sel_after", sel, 0);
      chk("midrst_err", err, 0);

      // MAX_HOLD=2 instance: one extra hold cycle is legal
      do_reset();
      step(3'b001);
      step(3'b001);
      chk("mh2_hold_err", err2, 0);
      chk("mh1_hold_err", err, 1);
      step(3'b000);
      chk("mh2_sel_valid", sel_valid2, 1);
      chk("mh2_sel", sel2, 1);
      chk("mh1_no_commit", sel_valid, 0);
      step(3'b001);
      step(3'b001);
      step(3'b001);
      chk("mh2_exhaust_err", err2, 1);
      chk("mh2_exhaust_cnt", err_cnt2, ecnt(1));
      step(3'b000);

      // err_cnt saturation
      do_reset();
      for (int i = 1; i <= 300; i++) begin
         step(3'b101);
         if (i == 254) chk("sat_254", err_cnt, ecnt(254));
         if (i == 255) chk("sat_255", err_cnt, ecnt(255));
         step(3'b000);
      end
      chk("sat_300", err_cnt, ecnt(255));
      chk("sat_err_clear", err, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
